// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the multi-read-port RAM.
// RAM_OUTPUT_REG_EN selects the two-stage read output (latency 2).
package ram_pkg;

    typedef enum logic {
        RAM_INIT,
        RAM_READY
    } ram_state_e;

`ifdef RAM_OUTPUT_REG_EN
    localparam int RAM_READ_LATENCY = 2;
`else
    localparam int RAM_READ_LATENCY = 1;
`endif

    // Low bit of lane `port` in a bus of equal-width packed lanes.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/ram_multi_read_port_if.sv
// ram_multi_read_port_if: write port, packed read ports and status.
// The RAM is the slave; the client driving requests is the master.
interface ram_multi_read_port_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_READ   = 2
);
    logic                           iWriteEnable;
    logic [ADDR_WIDTH-1:0]          iWriteAddress;
    logic [DATA_WIDTH-1:0]          iDataIn;
    logic [NUM_READ-1:0]            iReadEnable;
    logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddress;
    logic [NUM_READ*DATA_WIDTH-1:0] oDataOut;
    logic [NUM_READ-1:0]            oReadValid;
    logic                           oReady;
    logic                           oAddrError;

    modport master (
        output iWriteEnable, iWriteAddress, iDataIn,
        output iReadEnable, iReadAddress,
        input  oDataOut, oReadValid, oReady, oAddrError
    );

    modport slave (
        input  iWriteEnable, iWriteAddress, iDataIn,
        input  iReadEnable, iReadAddress,
        output oDataOut, oReadValid, oReady, oAddrError
    );

endinterface

// File: rtl/ram_read_port.sv
// ram_read_port: one registered read port with range check and write-first bypass.
// RAM_OUTPUT_REG_EN adds a second register stage on data, valid and error.
module ram_read_port
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ready,
    input  logic                  i_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_err
);
    localparam logic [ADDR_WIDTH:0] LP_SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);

    logic                  w_in_range;
    logic                  w_req;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_err;

    assign w_in_range = ({1'b0, i_addr} < LP_SIZE);
    assign w_req      = i_ready & i_en;
    // i_wr_en is already qualified by ready and write-address range
    assign w_bypass   = i_wr_en & (i_wr_addr == i_addr);

    always_comb begin
        w_data = '0;
        if (w_in_range) begin
            w_data = w_bypass ? i_wr_data : i_mem_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_req;
            r_err   <= w_req & ~w_in_range;
            if (w_req) begin
                r_data <= w_data;
            end
        end
    end

`ifdef RAM_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] r_data2;
    logic                  r_valid2;
    logic                  r_err2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data2  <= '0;
            r_valid2 <= 1'b0;
            r_err2   <= 1'b0;
        end else begin
            r_valid2 <= r_valid;
            r_err2   <= r_err;
            if (r_valid) begin
                r_data2 <= r_data;
            end
        end
    end

    assign o_data  = r_data2;
    assign o_valid = r_valid2;
    assign o_err   = r_err2;
`else
    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_err   = r_err;
`endif

endmodule

// File: rtl/ram_multi_read_port.sv
// ram_multi_read_port: shared scratch RAM, one write port, NUM_READ read ports.
// Define RAM_OUTPUT_REG_EN for read latency 2 (extra output register stage).
module ram_multi_read_port
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 256,
    parameter int NUM_READ   = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic                  Clock,
    input logic                  Reset,
    ram_multi_read_port_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   LP_SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(MEM_SIZE - 1);

    ram_state_e            r_state;
    ram_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

    logic                  w_ready;
    logic                  w_wr_in_range;
    logic                  w_wr_ok;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_din;
    logic                  r_wr_err;
    logic                  w_wr_err_q;
    logic [NUM_READ-1:0]   w_port_err;

    assign w_ready       = (r_state == RAM_READY);
    assign w_wr_in_range = ({1'b0, bus.iWriteAddress} < LP_SIZE);
    assign w_wr_ok       = w_ready & bus.iWriteEnable & w_wr_in_range;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= RAM_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_cnt_nxt;
        end
    end

    // The init sequencer and the client write share the single array port
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_init_cnt;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_init_cnt;
        w_mem_din   = INIT_VALUE;
        unique case (r_state)
            RAM_INIT: begin
                w_mem_we  = 1'b1;
                w_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == LP_LAST) begin
                    w_state_nxt = RAM_READY;
                    w_cnt_nxt   = '0;
                end
            end
            RAM_READY: begin
                w_mem_we   = w_wr_ok;
                w_mem_addr = bus.iWriteAddress;
                w_mem_din  = bus.iDataIn;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_ready & bus.iWriteEnable & ~w_wr_in_range;
        end
    end

`ifdef RAM_OUTPUT_REG_EN
    logic r_wr_err2;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_err2 <= 1'b0;
        end else begin
            r_wr_err2 <= r_wr_err;
        end
    end

    assign w_wr_err_q = r_wr_err2;
`else
    assign w_wr_err_q = r_wr_err;
`endif

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        localparam int LP_AL = slice_lo(p, ADDR_WIDTH);
        localparam int LP_DL = slice_lo(p, DATA_WIDTH);

        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_word;

        assign w_addr = bus.iReadAddress[LP_AL +: ADDR_WIDTH];
        assign w_word = r_mem[w_addr];

        ram_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .MEM_SIZE   (MEM_SIZE)
        ) u_port (
            .i_clk      (Clock),
            .i_rst      (Reset),
            .i_ready    (w_ready),
            .i_en       (bus.iReadEnable[p]),
            .i_addr     (w_addr),
            .i_mem_data (w_word),
            .i_wr_en    (w_wr_ok),
            .i_wr_addr  (bus.iWriteAddress),
            .i_wr_data  (bus.iDataIn),
            .o_data     (bus.oDataOut[LP_DL +: DATA_WIDTH]),
            .o_valid    (bus.oReadValid[p]),
            .o_err      (w_port_err[p])
        );
    end

    // Any number of same-cycle range errors collapse into one pulse
    assign bus.oAddrError = w_wr_err_q | (|w_port_err);
    assign bus.oReady     = w_ready;

endmodule

// File: tb/tb_ram_multi_read_port.sv
// tb_ram_multi_read_port: table vectors, corner sequences and a random
// run against an array model for ram_multi_read_port (full and 200-word).
module tb_ram_multi_read_port;
    import ram_pkg::*;

    localparam int L = RAM_READ_LATENCY;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    always #5 Clock = ~Clock;

    ram_multi_read_port_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_READ(2)) bus ();
    ram_multi_read_port_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_READ(2)) bus_s ();

    ram_multi_read_port #(
        .DATA_WIDTH(16), .ADDR_WIDTH(8), .MEM_SIZE(256),
        .NUM_READ(2), .INIT_VALUE(16'h0000)
    ) u_dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    ram_multi_read_port #(
        .DATA_WIDTH(16), .ADDR_WIDTH(8), .MEM_SIZE(200),
        .NUM_READ(2), .INIT_VALUE(16'h0000)
    ) u_dut_s (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_s)
    );

    typedef struct {
        logic        we;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic [1:0]  re;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [1:0]  ev;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    typedef struct {
        logic [1:0]  v;
        logic [15:0] d0;
        logic [15:0] d1;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_m [256];
    logic [15:0] h0, h1;
    vec_t        tv [8];
    exp_t        q [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drv(input logic we, input logic [7:0] wa,
                       input logic [15:0] wd, input logic [1:0] re,
                       input logic [7:0] a0, input logic [7:0] a1);
        bus.iWriteEnable  = we;
        bus.iWriteAddress = wa;
        bus.iDataIn       = wd;
        bus.iReadEnable   = re;
        bus.iReadAddress  = {a1, a0};
    endtask

    task automatic drv_s(input logic we, input logic [7:0] wa,
                         input logic [15:0] wd, input logic [1:0] re,
                         input logic [7:0] a0, input logic [7:0] a1);
        bus_s.iWriteEnable  = we;
        bus_s.iWriteAddress = wa;
        bus_s.iDataIn       = wd;
        bus_s.iReadEnable   = re;
        bus_s.iReadAddress  = {a1, a0};
    endtask

    task automatic idle();
        drv(1'b0, 8'd0, 16'h0, 2'b00, 8'd0, 8'd0);
    endtask

    task automatic idle_s();
        drv_s(1'b0, 8'd0, 16'h0, 2'b00, 8'd0, 8'd0);
    endtask

    // Waits for oReady on the full DUT and returns the cycle count.
    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.oReady && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, ns, bad, k;
        logic       we;
        logic [7:0] wa, a0, a1;
        logic [15:0] wd;
        logic [1:0] re;
        exp_t       e;

        tv[0] = '{1'b0, 8'd0,  16'h0,    2'b11, 8'd0,   8'd128, 2'b11, 16'h0,    16'h0};
        tv[1] = '{1'b0, 8'd0,  16'h0,    2'b11, 8'd255, 8'd128, 2'b11, 16'h0,    16'h0};
        tv[2] = '{1'b1, 8'd5,  16'hBEEF, 2'b00, 8'd0,   8'd0,   2'b00, 16'h0,    16'h0};
        tv[3] = '{1'b0, 8'd0,  16'h0,    2'b11, 8'd5,   8'd5,   2'b11, 16'hBEEF, 16'hBEEF};
        tv[4] = '{1'b1, 8'd7,  16'hAAAA, 2'b00, 8'd0,   8'd0,   2'b00, 16'hBEEF, 16'hBEEF};
        tv[5] = '{1'b1, 8'd7,  16'h1234, 2'b10, 8'd0,   8'd7,   2'b10, 16'hBEEF, 16'h1234};
        tv[6] = '{1'b0, 8'd0,  16'h0,    2'b01, 8'd7,   8'd0,   2'b01, 16'h1234, 16'h1234};
        tv[7] = '{1'b1, 8'd16, 16'hCAFE, 2'b11, 8'd16,  8'd7,   2'b11, 16'hCAFE, 16'h1234};

        // Reset values
        idle();
        idle_s();
        Reset = 1'b1;
        step();
        step();
        chk("rst_ready", 64'(bus.oReady), 64'd0);
        chk("rst_valid", 64'(bus.oReadValid), 64'd0);
        chk("rst_data", 64'(bus.oDataOut), 64'd0);
        chk("rst_err", 64'(bus.oAddrError), 64'd0);

        // Init: traffic during INIT must be ignored
        Reset = 1'b0;
        drv(1'b1, 8'd0, 16'hFFFF, 2'b11, 8'd0, 8'd255);
        n = 0;
        ns = 0;
        bad = 0;
        while (!bus.oReady && n < 300) begin
            step();
            n++;
            if (bus.oReadValid != 2'b00 || bus.oAddrError) bad++;
            if (bus_s.oReady && ns == 0) ns = n;
        end
        idle();
        chk("init_len", 64'(n), 64'd256);
        chk("init_ignored", 64'(bad), 64'd0);
        chk("init_len_s", 64'(ns), 64'd200);
        foreach (mem_m[i]) mem_m[i] = 16'h0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            drv(tv[i].we, tv[i].wa, tv[i].wd, tv[i].re, tv[i].a0, tv[i].a1);
            if (tv[i].we) mem_m[tv[i].wa] = tv[i].wd;
            step();
            idle();
            repeat (L - 1) step();
            chk($sformatf("vec%0d", i),
                64'({bus.oAddrError, bus.oReadValid, bus.oDataOut}),
                64'({1'b0, tv[i].ev, tv[i].e1, tv[i].e0}));
        end

        // Latency of a plain read
        drv(1'b0, 8'd0, 16'h0, 2'b11, 8'd5, 8'd5);
        k = 0;
        do begin
            step();
            idle();
            k++;
        end while (bus.oReadValid != 2'b11 && k < 5);
        chk("latency", 64'(k), 64'(L));
        chk("latency_data", 64'(bus.oDataOut), 64'({16'hBEEF, 16'hBEEF}));
        step();
        h0 = 16'hBEEF;
        h1 = 16'hBEEF;

        // Random traffic on a small address window to force bypass hits
        repeat (L - 1) q.push_back('{2'b00, 16'h0, 16'h0});
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 8'($urandom_range(0, 15));
            wd = 16'($urandom);
            re = 2'($urandom_range(0, 3));
            a0 = 8'($urandom_range(0, 15));
            a1 = 8'($urandom_range(0, 15));
            e.v  = re;
            e.d0 = (we && wa == a0) ? wd : mem_m[a0];
            e.d1 = (we && wa == a1) ? wd : mem_m[a1];
            q.push_back(e);
            drv(we, wa, wd, re, a0, a1);
            if (we) mem_m[wa] = wd;
            step();
            e = q.pop_front();
            if (e.v[0]) h0 = e.d0;
            if (e.v[1]) h1 = e.d1;
            chk("rand",
                64'({bus.oAddrError, bus.oReadValid, bus.oDataOut}),
                64'({1'b0, e.v, h1, h0}));
        end
        idle();
        repeat (L + 1) step();

        // Out-of-range on the 200-word instance
        drv_s(1'b1, 8'd210, 16'hDEAD, 2'b01, 8'd250, 8'd0);
        step();
        idle_s();
        repeat (L - 1) step();
        chk("rng_wr_rd",
            64'({bus_s.oAddrError, bus_s.oReadValid, bus_s.oDataOut[15:0]}),
            64'({1'b1, 2'b01, 16'h0}));
        step();
        chk("rng_pulse_end", 64'(bus_s.oAddrError), 64'd0);

        drv_s(1'b1, 8'd199, 16'h7777, 2'b11, 8'd199, 8'd200);
        step();
        idle_s();
        repeat (L - 1) step();
        chk("rng_edge",
            64'({bus_s.oAddrError, bus_s.oReadValid, bus_s.oDataOut}),
            64'({1'b1, 2'b11, 16'h0, 16'h7777}));

        drv_s(1'b1, 8'd255, 16'h9999, 2'b11, 8'd220, 8'd201);
        step();
        idle_s();
        repeat (L - 1) step();
        chk("rng_multi",
            64'({bus_s.oAddrError, bus_s.oReadValid, bus_s.oDataOut}),
            64'({1'b1, 2'b11, 16'h0, 16'h0}));
        step();
        chk("rng_multi_end", 64'(bus_s.oAddrError), 64'd0);

        drv_s(1'b0, 8'd0, 16'h0, 2'b11, 8'd10, 8'd199);
        step();
        idle_s();
        repeat (L - 1) step();
        chk("rng_unchanged",
            64'({bus_s.oAddrError, bus_s.oReadValid, bus_s.oDataOut}),
            64'({1'b0, 2'b11, 16'h7777, 16'h0}));

        // Reset in the middle of a pending read
        drv(1'b1, 8'd3, 16'h5555, 2'b00, 8'd0, 8'd0);
        step();
        drv(1'b0, 8'd0, 16'h0, 2'b01, 8'd3, 8'd0);
        Reset = 1'b1;
        step();
        chk("mid_rst_valid", 64'(bus.oReadValid), 64'd0);
        chk("mid_rst_ready", 64'(bus.oReady), 64'd0);
        chk("mid_rst_data", 64'(bus.oDataOut), 64'd0);
        Reset = 1'b0;
        idle();
        wait_ready(n);
        chk("reinit_len", 64'(n), 64'd256);
        drv(1'b0, 8'd0, 16'h0, 2'b11, 8'd3, 8'd5);
        step();
        idle();
        repeat (L - 1) step();
        chk("reinit_clear",
            64'({bus.oAddrError, bus.oReadValid, bus.oDataOut}),
            64'({1'b0, 2'b11, 16'h0, 16'h0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_multi_read_port.md
Name: ram_multi_read_port

Overview:
Parametrised successor to the team's two-read-port register RAM.
- One synchronous write port and NUM_READ independent registered read ports.
- Per-port read-valid strobes and write-first bypass.
- After reset, a hardware init sequencer clears the array before the block accepts traffic.
- Sits between the LCD/display controllers and their datapath as a shared scratch/frame-line store.

Parameters:
DATA_WIDTH, 16, word width in bits
ADDR_WIDTH, 8, address width in bits
MEM_SIZE, 256, number of words; must satisfy 1 <= MEM_SIZE <= 2**ADDR_WIDTH
NUM_READ, 2, number of read ports; must be >= 1
INIT_VALUE, 0, value written to every word by the init sequencer

Ports:
Clock  input  1  single clock; all logic on its rising edge
Reset  input  1  synchronous, active-high reset
iWriteEnable  input  1  write request
iWriteAddress  input  ADDR_WIDTH  write address
iDataIn  input  DATA_WIDTH  write data
iReadEnable  input  NUM_READ  per-port read request; bit p belongs to port p
iReadAddress  input  NUM_READ*ADDR_WIDTH  packed read addresses; port p occupies [p*ADDR_WIDTH +: ADDR_WIDTH]
oDataOut  output  NUM_READ*DATA_WIDTH  packed registered read data; same packing as iReadAddress
oReadValid  output  NUM_READ  per-port one-cycle strobe qualifying oDataOut
oReady  output  1  high when the array is initialised and accepting traffic
oAddrError  output  1  one-cycle pulse on any out-of-range access

Behaviour:
- Clocking and reset: Clock is the only clock. Reset is synchronous and active-high.
- Reset values: oDataOut=0, oReadValid=0, oReady=0, oAddrError=0; FSM=INIT, init counter=0.
- FSM state INIT:
  - Each cycle writes INIT_VALUE to Ram[counter], then counter increments.
  - When counter == MEM_SIZE-1 and that word is written, the next state is READY.
  - INIT therefore lasts exactly MEM_SIZE cycles after Reset deasserts.
  - oReady=0 throughout; iWriteEnable and iReadEnable are ignored (no write, no valid, no error).
- FSM state READY: oReady=1. Stays in READY until Reset.
- Reset asserted mid-INIT or mid-READY: next edge returns to INIT with counter=0 and all outputs at reset values. Memory is fully re-cleared.
- Write (READY): if iWriteEnable and iWriteAddress < MEM_SIZE, then Ram[iWriteAddress] <= iDataIn at the edge.
- Read (READY): if iReadEnable[p], port p registers data at the edge; oDataOut[p] and oReadValid[p]=1 are visible the next cycle (latency 1).
- Read data rules, per port:
  - If iReadEnable[p]=0: oReadValid[p]=0 next cycle and oDataOut[p] holds its previous value.
  - Write-first bypass: if a write and a read of the same valid address occur in the same cycle, the read returns iDataIn, not the old contents.
  - Multiple ports may read the same address in the same cycle; each returns identical data.
- Out-of-range (address >= MEM_SIZE):
  - A write is dropped.
  - A read returns 0 with oReadValid[p]=1.
  - Either case pulses oAddrError=1 for one cycle, aligned with the read-data cycle.
  - Multiple simultaneous errors produce a single pulse.

Optional Feature:
Macro RAM_OUTPUT_REG_EN.
- Defined: an extra output register stage is added on oDataOut and oReadValid, giving read latency 2. oAddrError is delayed to match. Bypass still compares addresses at request time.
- Undefined: read latency 1 as above.
- Reset clears both stages in either build.

Decomposition:
- Package ram_pkg holds:
  - FSM state enum {RAM_INIT, RAM_READY}.
  - Latency constant RAM_READ_LATENCY (1, or 2 under the macro).
  - A function for the packed-slice offset.
- Sub-module ram_read_port: one per port, instantiated by generate over NUM_READ. It contains the range check, bypass mux, output register(s) and valid strobe.
- The top level owns the array, the write logic, the init FSM and the error OR.

Test Plan:
- Init: Reset 1 cycle, then idle -> oReady=0 for exactly 256 cycles, rises on cycle 257. Reads at 0, 128 and 255 all return 0x0000.
- Basic: write 0xBEEF at address 5, next cycle read port0 @5 and port1 @5 -> one cycle later both oDataOut=0xBEEF, oReadValid=2'b11.
- Bypass: same cycle write 0x1234 @7 (old value 0xAAAA) and port1 reads @7 -> port1 returns 0x1234.
- Range: with MEM_SIZE=200, write @210 and port0 read @250 -> oAddrError single pulse, port0 data 0x0000 with valid=1, array unchanged.
- Reset mid-op: fill address 3 with 0x5555, assert Reset during a pending read -> next cycle oReadValid=0 and oReady=0. After 256 cycles, address 3 reads 0x0000.
- Macro: build with RAM_OUTPUT_REG_EN, repeat the Basic case -> data and valid appear 2 cycles after the request.
